// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu
// Description : Multi-cycle ALU with a valid/ready handshake on both sides.
//               Simple ops finish one cycle after accept. MUL/MULHU use a
//               shift-add multiplier and DIVU/REMU use a restoring divider.
//               Both take exactly WIDTH iteration cycles.
// Ports       : clk, reset (sync, active-high)
//               in_valid/in_ready, operand1, operand2, aluOp  -- request side
//               out_valid/out_ready, aluResult, aluZero       -- result side
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       aluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic             aluZero
);

    localparam int c_sh_w = $clog2(WIDTH);

    localparam logic [3:0] c_op_add   = 4'd0;
    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [3:0] c_op_and   = 4'd2;
    localparam logic [3:0] c_op_or    = 4'd3;
    localparam logic [3:0] c_op_mul   = 4'd4;
    localparam logic [3:0] c_op_sll   = 4'd5;
    localparam logic [3:0] c_op_xor   = 4'd6;
    localparam logic [3:0] c_op_srl   = 4'd7;
    localparam logic [3:0] c_op_sra   = 4'd8;
    localparam logic [3:0] c_op_slt   = 4'd9;
    localparam logic [3:0] c_op_sltu  = 4'd10;
    localparam logic [3:0] c_op_mulhu = 4'd11;
    localparam logic [3:0] c_op_divu  = 4'd12;
    localparam logic [3:0] c_op_remu  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand (MUL*) or divisor (DIV*)
    logic [WIDTH-1:0]   r_hi;       // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier bits / dividend-then-quotient
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;

    logic               w_in_multi;
    logic               w_in_div;
    logic               w_is_div;
    logic [c_sh_w-1:0]  w_sh;
    logic [WIDTH-1:0]   w_alu;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [WIDTH-1:0]   w_busy_res;
    logic               w_last;

    // ------------------------------------------------------------------
    // Request decode and single-cycle datapath (works on live inputs; its
    // value is only captured on the accept edge)
    // ------------------------------------------------------------------
    always_comb begin
        w_in_multi = (aluOp == c_op_mul) || (aluOp == c_op_mulhu) ||
                     (aluOp == c_op_divu) || (aluOp == c_op_remu);
        w_in_div   = (aluOp == c_op_divu) || (aluOp == c_op_remu);
        w_sh       = operand2[c_sh_w-1:0];
        w_alu      = '0;
        case (aluOp)
            c_op_add:  w_alu = operand1 + operand2;
            c_op_sub:  w_alu = operand1 - operand2;
            c_op_and:  w_alu = operand1 & operand2;
            c_op_or:   w_alu = operand1 | operand2;
            c_op_sll:  w_alu = operand1 << w_sh;
            c_op_xor:  w_alu = operand1 ^ operand2;
            c_op_srl:  w_alu = operand1 >> w_sh;
            c_op_sra:  w_alu = WIDTH'($signed(operand1) >>> w_sh);
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            default:   w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one multiplier bit or one quotient bit per cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_is_div  = (r_op == c_op_divu) || (r_op == c_op_remu);

        // Shift-add: add multiplicand into the high half when the current
        // multiplier LSB is set, then shift the whole 2*WIDTH product right.
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

        // Restoring division: bring in the next dividend bit, keep the
        // difference only if it did not go negative. A zero divisor always
        // "succeeds", which naturally yields all-ones / the dividend.
        w_trial   = {r_hi, r_lo[WIDTH-1]};
        w_diff    = w_trial - {1'b0, r_opnd};
        w_ge      = ~w_diff[WIDTH];
        w_div_hi  = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_div_lo  = {r_lo[WIDTH-2:0], w_ge};

        w_step_hi = w_is_div ? w_div_hi : w_mul_hi;
        w_step_lo = w_is_div ? w_div_lo : w_mul_lo;

        // MUL and DIVU deliver the low register, MULHU and REMU the high one
        w_busy_res = ((r_op == c_op_mul) || (r_op == c_op_divu)) ? w_step_lo : w_step_hi;
        w_last     = (r_cnt <= CNT_W'(1));
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next_state = w_in_multi ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (w_last)
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Return to IDLE only; a new accept waits one more cycle
                if (out_ready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= aluOp;
                        if (w_in_multi) begin
                            r_cnt <= CNT_W'(WIDTH);
                            r_hi  <= '0;
                            if (w_in_div) begin
                                r_lo   <= operand1;
                                r_opnd <= operand2;
                            end else begin
                                r_lo   <= operand2;
                                r_opnd <= operand1;
                            end
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                        end
                    end
                end
                S_BUSY: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - CNT_W'(1);
                    // Result register is only written on the final iteration
                    if (w_last) begin
                        r_result <= w_busy_res;
                        r_zero   <= (w_busy_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign aluResult = r_result;
    assign aluZero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mc_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_alu
// Description : Self-checking bench for mc_alu (WIDTH=32). Expected results
//               and latencies are queued when a request is driven and popped
//               when the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  aluOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluResult;
    logic        aluZero;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    mc_alu #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .aluOp     (aluOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluResult (aluResult),
        .aluZero   (aluZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  s;
        p = {32'b0, a} * {32'b0, b};
        s = b[4:0];
        case (op)
            4'd0:    model = a + b;
            4'd1:    model = a - b;
            4'd2:    model = a & b;
            4'd3:    model = a | b;
            4'd4:    model = p[31:0];
            4'd5:    model = a << s;
            4'd6:    model = a ^ b;
            4'd7:    model = a >> s;
            4'd8:    model = $signed(a) >>> s;
            4'd9:    model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   model = (a < b) ? 32'd1 : 32'd0;
            4'd11:   model = p[63:32];
            4'd12:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   model = (b == 0) ? a : a % b;
            default: model = 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op);
        latency = (op == 4'd4 || op == 4'd11 || op == 4'd12 || op == 4'd13) ? 33 : 1;
    endfunction

    // Drive one request at a negedge, then follow it to consumption.
    // hold > 0 keeps out_ready low for that many DONE cycles while pulsing
    // in_valid with unrelated operands.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        int          k;
        logic [31:0] held;
        logic        moved;
        logic [31:0] exp_r;
        int          exp_l;

        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);

        exp_q.push_back(model(op, a, b));
        lat_q.push_back(latency(op));

        in_valid  = 1'b1;
        aluOp     = op;
        operand1  = a;
        operand2  = b;
        out_ready = (hold == 0);
        held      = aluResult;
        @(negedge clk);
        // Scramble inputs after accept; they must not matter
        in_valid = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        aluOp    = 4'($urandom_range(0, 15));

        k = 1;
        moved = 1'b0;
        while (!out_valid && k < 100) begin
            if (aluResult !== held) moved = 1'b1;
            chk({tag, "_no_ready_busy"}, in_ready, 0);
            @(negedge clk);
            k++;
        end
        exp_r = exp_q.pop_front();
        exp_l = lat_q.pop_front();
        chk({tag, "_valid"},   out_valid, 1);
        chk({tag, "_latency"}, k, exp_l);
        chk({tag, "_stable"},  moved, 0);
        chk({tag, "_result"},  aluResult, exp_r);
        chk({tag, "_zero"},    aluZero, (exp_r == 0));

        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            operand1 = $urandom;
            operand2 = $urandom;
            aluOp    = 4'd0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_res"},   aluResult, exp_r);
            chk({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_consumed"}, out_valid, 0);
        chk({tag, "_idle"},     in_ready, 1);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b1;            // must be ignored while in reset
        aluOp     = 4'd0;
        operand1  = 32'd7;
        operand2  = 32'd9;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    aluResult, 0);
        chk("rst_zero",      aluZero, 1);
        chk("rst_in_ready",  in_ready, 1);

        run_op("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("mul_lo",    4'd4,  32'h0001_0000, 32'h0001_0000, 0);
        run_op("mulhu",     4'd11, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("divu",      4'd12, 32'd100, 32'd7, 0);
        run_op("remu",      4'd13, 32'd100, 32'd7, 0);
        run_op("divu_z",    4'd12, 32'h0000_1234, 32'd0, 0);
        run_op("remu_z",    4'd13, 32'h0000_1234, 32'd0, 0);
        run_op("sra",       4'd8,  32'h8000_0000, 32'h0000_0024, 0);
        run_op("slt",       4'd9,  32'hFFFF_FFFF, 32'd0, 0);
        run_op("sltu",      4'd10, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("sub_wrap",  4'd1,  32'd0, 32'd1, 0);
        run_op("and",       4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op("or",        4'd3,  32'hF000_0001, 32'h0000_1000, 0);
        run_op("xor",       4'd6,  32'hAAAA_5555, 32'hFFFF_0000, 0);
        run_op("sll",       4'd5,  32'h0000_0003, 32'hFFFF_FFE1, 0);
        run_op("srl",       4'd7,  32'h8000_0000, 32'h0000_003F, 0);
        run_op("op14",      4'd14, 32'h1234_5678, 32'h1, 0);
        run_op("op15",      4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_big",   4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu_big", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu_bp",   4'd12, 32'hDEAD_BEEF, 32'h0000_0013, 10);
        run_op("add_bp",    4'd0,  32'd40, 32'd2, 3);

        for (int i = 0; i < 10; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        // Leave a nonzero result behind, then abort a DIVU at busy cycle 10
        run_op("slt_pre", 4'd9, 32'h8000_0000, 32'd1, 0);
        in_valid = 1'b1;
        aluOp    = 4'd12;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_valid", out_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result",    aluResult, 0);
        chk("abort_zero",      aluZero, 1);
        chk("abort_in_ready",  in_ready, 1);
        repeat (40) begin
            @(negedge clk);
            chk("abort_never_valid", out_valid, 0);
        end
        run_op("add_post", 4'd0, 32'd2, 32'd3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
